// File: rtl/blk_d133c3_pkg.sv
// Shared types and sizing helpers for the debug-master packet arbiter.
package blk_d133c3_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Grant index width; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blk_d133c3_if.sv
// Bundle of the NUM_IN packet sources plus the single channelized output stream.
interface blk_d133c3_if #(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_startofpacket;
    logic [NUM_IN-1:0]        in_endofpacket;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_startofpacket;
    logic                     out_endofpacket;
    logic [CHANNEL_W-1:0]     out_channel;

    modport master (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
    );

    modport slave (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
    );
endinterface

// File: rtl/blk_d133c3_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module blk_d133c3_rr_arbiter
    import blk_d133c3_pkg::*;
#(
    parameter int NUM_IN = 4,
    localparam int GW    = grant_w(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [GW-1:0]     last_grant,
    output logic [NUM_IN-1:0] grant_oh,
    output logic [GW-1:0]     grant_idx
);

    always_comb begin
        logic          found;
        logic [GW-1:0] sel;
        int            pos;
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        pos       = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            pos = (int'(last_grant) + k) % NUM_IN;
            sel = GW'(pos);
            if (!found && req[sel]) begin
                found         = 1'b1;
                grant_idx     = sel;
                grant_oh[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blk_d133c3.sv
// Packet-level round-robin merge of NUM_IN Avalon-ST sources into one channelized
// stream; grant is held for a whole packet, output goes through one register stage.
//
//   state  | meaning
//   IDLE   | between packets; grant chosen round-robin each cycle
//   LOCKED | mid-packet; grant frozen on grant_q until the EOP beat is accepted
module blk_d133c3
    import blk_d133c3_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    blk_d133c3_if.slave  bus,
    output logic         busy,
    output logic         protocol_err
);

    localparam int GW = grant_w(NUM_IN);

    state_t              state;
    state_t              state_nxt;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       arb_idx;
    logic [NUM_IN-1:0]   arb_oh;
    logic                stage_ok;
    logic                accept;
    logic                sel_sop;
    logic                sel_eop;
    logic [DATA_W-1:0]   sel_data;

    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_sop_q;
    logic                out_eop_q;
    logic [CHANNEL_W-1:0] out_channel_q;

    blk_d133c3_rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .req        (bus.in_valid),
        .last_grant (last_grant),
        .grant_oh   (arb_oh),
        .grant_idx  (arb_idx)
    );

    assign stage_ok = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !sel_eop) state_nxt = LOCKED;
            LOCKED:  if (accept && sel_eop)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready follows the grant only, never the granted source's own valid.
    always_comb begin
        busy        = (state == LOCKED);
        grant       = (state == LOCKED) ? grant_q : arb_idx;
        bus.in_ready = '0;
        if (stage_ok) begin
            if (state == LOCKED) bus.in_ready[grant_q] = 1'b1;
            else                 bus.in_ready = arb_oh;
        end
        accept   = bus.in_valid[grant] && stage_ok;
        sel_sop  = bus.in_startofpacket[grant];
        sel_eop  = bus.in_endofpacket[grant];
        sel_data = bus.in_data[grant*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q       <= '0;
            last_grant    <= GW'(NUM_IN - 1);
            protocol_err  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_channel_q <= '0;
        end else begin
            if (state == IDLE && accept) grant_q <= grant;
            if (accept && sel_eop)       last_grant <= grant;
            protocol_err <= accept && ((state == IDLE && !sel_sop) ||
                                       (state == LOCKED && sel_sop));
            if (stage_ok) begin
                out_valid_q <= accept;
                if (accept) begin
                    out_data_q    <= sel_data;
                    out_sop_q     <= sel_sop;
                    out_eop_q     <= sel_eop;
                    out_channel_q <= CHANNEL_W'(grant);
                end
            end
        end
    end

    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.out_startofpacket = out_sop_q;
    assign bus.out_endofpacket   = out_eop_q;
    assign bus.out_channel       = out_channel_q;

endmodule

// File: tb/tb_blk_d133c3.sv
// Directed bench for the packet arbiter: round-robin, packet lock, backpressure,
// protocol error pulse and reset mid-packet.
module tb_blk_d133c3;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    logic protocol_err;
    int   n_vec = 0;
    int   n_err = 0;

    blk_d133c3_if #(.NUM_IN(4), .DATA_W(8), .CHANNEL_W(8)) bus ();

    blk_d133c3 #(.NUM_IN(4), .DATA_W(8), .CHANNEL_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [7:0] d,
                           input logic s, input logic e);
        bus.in_valid[i]         = v;
        bus.in_data[i*8 +: 8]   = d;
        bus.in_startofpacket[i] = s;
        bus.in_endofpacket[i]   = e;
    endtask

    task automatic out_beat(input string tag, input logic [7:0] d, input logic [7:0] ch);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_data"}, bus.out_data, d);
        check({tag, "_ch"}, bus.out_channel, ch);
    endtask

    initial begin
        reset_n              = 1'b0;
        bus.in_valid         = '0;
        bus.in_data          = '0;
        bus.in_startofpacket = '0;
        bus.in_endofpacket   = '0;
        bus.out_ready        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_ch", bus.out_channel, 0);
        reset_n = 1'b1;

        // all four sources offering single-beat packets
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 8'(8'h10 + i), 1'b1, 1'b1);
        #1;
        check("rr_ready0", bus.in_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            step();
            out_beat("rr", 8'(8'h10 + (k % 4)), 8'(k % 4));
            check("rr_busy", busy, 0);
        end
        bus.in_valid = '0;
        step();
        check("rr_drain", bus.out_valid, 0);

        // src2 four-beat packet while src0 waits
        set_src(2, 1'b1, 8'hA0, 1'b1, 1'b0);
        set_src(0, 1'b1, 8'h10, 1'b1, 1'b1);
        #1;
        check("lk_ready_first", bus.in_ready, 4'b0100);
        step();
        out_beat("lk0", 8'hA0, 8'd2);
        check("lk0_sop", bus.out_startofpacket, 1);
        check("lk0_busy", busy, 1);
        check("lk_ready_locked", bus.in_ready, 4'b0100);
        set_src(2, 1'b1, 8'hA1, 1'b0, 1'b0);
        step();
        out_beat("lk1", 8'hA1, 8'd2);
        check("lk1_busy", busy, 1);
        set_src(2, 1'b1, 8'hA2, 1'b0, 1'b0);
        step();
        out_beat("lk2", 8'hA2, 8'd2);
        check("lk2_busy", busy, 1);
        set_src(2, 1'b1, 8'hA3, 1'b0, 1'b1);
        step();
        out_beat("lk3", 8'hA3, 8'd2);
        check("lk3_eop", bus.out_endofpacket, 1);
        check("lk3_busy", busy, 0);
        set_src(2, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check("lk_ready_after", bus.in_ready, 4'b0001);
        step();
        out_beat("lk_src0", 8'h10, 8'd0);
        bus.in_valid = '0;
        step();
        check("lk_drain", bus.out_valid, 0);

        // backpressure mid-packet on src1
        set_src(1, 1'b1, 8'hB0, 1'b1, 1'b0);
        step();
        out_beat("bp0", 8'hB0, 8'd1);
        set_src(1, 1'b1, 8'hB1, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        check("bp_ready_low", bus.in_ready, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step();
            out_beat("bp_hold", 8'hB0, 8'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_back", bus.in_ready, 4'b0010);
        step();
        out_beat("bp1", 8'hB1, 8'd1);
        set_src(1, 1'b1, 8'hB2, 1'b0, 1'b1);
        step();
        out_beat("bp2", 8'hB2, 8'd1);
        check("bp2_eop", bus.out_endofpacket, 1);
        set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("bp_drain", bus.out_valid, 0);

        // beat without SOP while idle
        set_src(1, 1'b1, 8'hC5, 1'b0, 1'b1);
        step();
        out_beat("pe", 8'hC5, 8'd1);
        check("pe_pulse", protocol_err, 1);
        check("pe_busy", busy, 0);
        set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("pe_clear", protocol_err, 0);
        check("pe_drain", bus.out_valid, 0);

        // reset while src3 holds the grant
        set_src(3, 1'b1, 8'hD0, 1'b1, 1'b0);
        step();
        out_beat("rs_lock", 8'hD0, 8'd3);
        check("rs_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rs_async_valid", bus.out_valid, 0);
        check("rs_async_busy", busy, 0);
        #2;
        reset_n = 1'b1;
        set_src(3, 1'b1, 8'hD1, 1'b1, 1'b1);
        set_src(0, 1'b1, 8'hE0, 1'b1, 1'b1);
        #1;
        check("rs_ready", bus.in_ready, 4'b0001);
        step();
        out_beat("rs_src0", 8'hE0, 8'd0);
        step();
        out_beat("rs_src3", 8'hD1, 8'd3);
        bus.in_valid = '0;
        step();
        check("rs_drain", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
